// File: rtl/cnn_pool_pkg.sv
// Shared types and helpers for the 3D pooling engine.
// Mode and state encodings plus output-size and shift helpers.
package cnn_pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } pool_state_e;

    localparam int DEF_POOL_SIZE = 2;
    localparam int DEF_POOL_SHIFT = 3 * $clog2(DEF_POOL_SIZE);

    function automatic int out_size(input int n, input int p, input int s);
        return (n - p) / s + 1;
    endfunction

    function automatic int pool_shift(input int p);
        return 3 * $clog2(p);
    endfunction

endpackage

// File: rtl/cnn_pool_window_acc.sv
// Window accumulator: running signed max, or wide sum shifted down
// by log2 of the window volume for the average.
module cnn_pool_window_acc
    import cnn_pool_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SHIFT  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     acc_en,
    input  logic                     init,
    input  pool_mode_e               mode,
    input  logic signed [DATA_W-1:0] data,
    output logic signed [DATA_W-1:0] result
);

    localparam int SUM_W = DATA_W + SHIFT;

    logic signed [SUM_W-1:0] acc_q, acc_d;
    logic signed [SUM_W-1:0] data_x;
    logic signed [SUM_W-1:0] avg;

    always_comb begin
        data_x = SUM_W'(data);
        acc_d  = acc_q;
        if (acc_en) begin
            if (init) begin
                acc_d = data_x;
            end else if (mode == POOL_AVG) begin
                acc_d = acc_q + data_x;
            end else if (data > $signed(acc_q[DATA_W-1:0])) begin
                acc_d = data_x;
            end
        end
        avg    = acc_q >>> SHIFT;
        result = (mode == POOL_MAX) ? acc_q[DATA_W-1:0] : avg[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/cnn_3d_pool_engine.sv
// 3D max/average pooling engine: walks each P^3 window through a
// 1-cycle-latency feature RAM and streams pooled values downstream.
module cnn_3d_pool_engine
    import cnn_pool_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int IMG_SIZE    = 4,
    parameter int POOL_SIZE   = 2,
    parameter int STRIDE      = 2,
    parameter int NUM_FILTERS = 3,
    parameter int ADDR_W      = $clog2(NUM_FILTERS * IMG_SIZE ** 3)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]        out_idx
);

    localparam int OUT      = out_size(IMG_SIZE, POOL_SIZE, STRIDE);
    localparam int SHIFT    = pool_shift(POOL_SIZE);
    localparam int CW       = $clog2(IMG_SIZE) + 1;
    localparam int FW       = $clog2(NUM_FILTERS) + 1;
    localparam int N2       = IMG_SIZE * IMG_SIZE;
    localparam int N3       = N2 * IMG_SIZE;
    localparam int LAST_IDX = NUM_FILTERS * OUT ** 3 - 1;

    localparam logic [CW-1:0] W_LAST = CW'(POOL_SIZE - 1);
    localparam logic [CW-1:0] O_LAST = CW'(OUT - 1);

    pool_state_e state_q, state_d;
    pool_mode_e  mode_q, mode_d;

    logic [CW-1:0] wrow_q, wrow_d, wcol_q, wcol_d, wdep_q, wdep_d;
    logic [CW-1:0] orow_q, orow_d, ocol_q, ocol_d, odep_q, odep_d;
    logic [FW-1:0] filt_q, filt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic rd_vld_q, rd_vld_d;
    logic rd_first_q, rd_first_d;

    int a_row, a_col, a_dep, a_full;

    always_comb begin
        a_row  = int'(orow_q) * STRIDE + int'(wrow_q);
        a_col  = int'(ocol_q) * STRIDE + int'(wcol_q);
        a_dep  = int'(odep_q) * STRIDE + int'(wdep_q);
        a_full = int'(filt_q) * N3 + a_row * N2 + a_col * IMG_SIZE + a_dep;
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wrow_d     = wrow_q;
        wcol_d     = wcol_q;
        wdep_d     = wdep_q;
        orow_d     = orow_q;
        ocol_d     = ocol_q;
        odep_d     = odep_q;
        filt_d     = filt_q;
        idx_d      = idx_q;
        rd_vld_d   = (state_q == ISSUE);
        rd_first_d = (state_q == ISSUE) && (wrow_q == '0)
                     && (wcol_q == '0) && (wdep_q == '0);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    mode_d  = pool_mode_e'(mode);
                    wrow_d  = '0;
                    wcol_d  = '0;
                    wdep_d  = '0;
                    orow_d  = '0;
                    ocol_d  = '0;
                    odep_d  = '0;
                    filt_d  = '0;
                    idx_d   = '0;
                end
            end
            ISSUE: begin
                // depth fastest, then column, then row
                if (wdep_q == W_LAST) begin
                    wdep_d = '0;
                    if (wcol_q == W_LAST) begin
                        wcol_d = '0;
                        if (wrow_q == W_LAST) begin
                            wrow_d  = '0;
                            state_d = DRAIN;
                        end else begin
                            wrow_d = wrow_q + 1'b1;
                        end
                    end else begin
                        wcol_d = wcol_q + 1'b1;
                    end
                end else begin
                    wdep_d = wdep_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (idx_q == ADDR_W'(LAST_IDX)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        idx_d   = idx_q + 1'b1;
                        if (odep_q == O_LAST) begin
                            odep_d = '0;
                            if (ocol_q == O_LAST) begin
                                ocol_d = '0;
                                if (orow_q == O_LAST) begin
                                    orow_d = '0;
                                    filt_d = filt_q + 1'b1;
                                end else begin
                                    orow_d = orow_q + 1'b1;
                                end
                            end else begin
                                ocol_d = ocol_q + 1'b1;
                            end
                        end else begin
                            odep_d = odep_q + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= POOL_MAX;
            wrow_q     <= '0;
            wcol_q     <= '0;
            wdep_q     <= '0;
            orow_q     <= '0;
            ocol_q     <= '0;
            odep_q     <= '0;
            filt_q     <= '0;
            idx_q      <= '0;
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wrow_q     <= wrow_d;
            wcol_q     <= wcol_d;
            wdep_q     <= wdep_d;
            orow_q     <= orow_d;
            ocol_q     <= ocol_d;
            odep_q     <= odep_d;
            filt_q     <= filt_d;
            idx_q      <= idx_d;
            rd_vld_q   <= rd_vld_d;
            rd_first_q <= rd_first_d;
        end
    end

    cnn_pool_window_acc #(
        .DATA_W (DATA_W),
        .SHIFT  (SHIFT)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .acc_en (rd_vld_q),
        .init   (rd_first_q),
        .mode   (mode_q),
        .data   (rd_data),
        .result (out_data)
    );

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign rd_en     = (state_q == ISSUE);
    assign rd_addr   = (state_q == ISSUE) ? ADDR_W'(a_full) : '0;
    assign out_valid = (state_q == EMIT);
    assign out_idx   = idx_q;

endmodule

// File: tb/tb_cnn_3d_pool_engine.sv
// Bench for cnn_3d_pool_engine: three configurations share one RAM
// model and are checked against a loop-nest reference of the pooling.
module tb_cnn_3d_pool_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic mode;
    logic out_ready;
    int   sel;

    logic signed [15:0] ram [0:255];

    logic start_a, start_b, start_c;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;
    logic rd_en_a, rd_en_b, rd_en_c;
    logic [7:0] rd_addr_a, rd_addr_b;
    logic [4:0] rd_addr_c;
    logic signed [15:0] rd_data_a, rd_data_b, rd_data_c;
    logic ov_a, ov_b, ov_c;
    logic signed [15:0] od_a, od_b, od_c;
    logic [7:0] oi_a, oi_b;
    logic [4:0] oi_c;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    cnn_3d_pool_engine u_a (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode),
        .busy(busy_a), .done(done_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .rd_data(rd_data_a), .out_valid(ov_a), .out_ready(out_ready),
        .out_data(od_a), .out_idx(oi_a)
    );

    cnn_3d_pool_engine #(
        .IMG_SIZE(5), .POOL_SIZE(2), .STRIDE(3), .NUM_FILTERS(2)
    ) u_b (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode),
        .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .out_valid(ov_b), .out_ready(out_ready),
        .out_data(od_b), .out_idx(oi_b)
    );

    cnn_3d_pool_engine #(
        .IMG_SIZE(3), .POOL_SIZE(1), .STRIDE(1), .NUM_FILTERS(1)
    ) u_c (
        .clk(clk), .reset(reset), .start(start_c), .mode(mode),
        .busy(busy_c), .done(done_c), .rd_en(rd_en_c), .rd_addr(rd_addr_c),
        .rd_data(rd_data_c), .out_valid(ov_c), .out_ready(out_ready),
        .out_data(od_c), .out_idx(oi_c)
    );

    always @(posedge clk) begin
        rd_data_a <= ram[rd_addr_a];
        rd_data_b <= ram[rd_addr_b];
        rd_data_c <= ram[rd_addr_c];
    end

    logic m_busy, m_done, m_rd_en, m_ov;
    logic [7:0] m_rd_addr, m_oi;
    logic signed [15:0] m_od;

    always_comb begin
        m_busy = busy_a; m_done = done_a; m_rd_en = rd_en_a;
        m_rd_addr = rd_addr_a; m_ov = ov_a; m_od = od_a; m_oi = oi_a;
        if (sel == 1) begin
            m_busy = busy_b; m_done = done_b; m_rd_en = rd_en_b;
            m_rd_addr = rd_addr_b; m_ov = ov_b; m_od = od_b; m_oi = oi_b;
        end else if (sel == 2) begin
            m_busy = busy_c; m_done = done_c; m_rd_en = rd_en_c;
            m_rd_addr = 8'(rd_addr_c); m_ov = ov_c; m_od = od_c;
            m_oi = 8'(oi_c);
        end
    end

    int pn[3] = '{4, 5, 3};
    int pp[3] = '{2, 2, 1};
    int ps[3] = '{2, 3, 1};
    int pf[3] = '{3, 2, 1};

    int n_checks = 0;
    int n_err = 0;
    int exp_addr[$];
    int exp_data[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < 256; i++) begin
            case (kind)
                0: ram[i] = 16'(i);
                1: ram[i] = -16'sd3;
                2: ram[i] = 16'(-32768 + ((i >> 4) & 1) * 4
                                + ((i >> 2) & 1) * 2 + (i & 1));
                3: ram[i] = (i == 0) ? -16'sd1 : 16'sd0;
                default: ram[i] = 16'($urandom);
            endcase
        end
    endtask

    // plain loop-nest pooling: collect the window, take max or floor mean
    task automatic build_model(input int s, input int md);
        int n, p, st, f, o, cnt, acc, v, a, q;
        n = pn[s]; p = pp[s]; st = ps[s]; f = pf[s];
        o = (n - p) / st + 1;
        cnt = p * p * p;
        exp_addr.delete();
        exp_data.delete();
        for (int ff = 0; ff < f; ff++)
        for (int r = 0; r < o; r++)
        for (int c = 0; c < o; c++)
        for (int d = 0; d < o; d++) begin
            acc = 0;
            for (int wr = 0; wr < p; wr++)
            for (int wc = 0; wc < p; wc++)
            for (int wd = 0; wd < p; wd++) begin
                a = ff * n * n * n + (r * st + wr) * n * n
                    + (c * st + wc) * n + (d * st + wd);
                exp_addr.push_back(a);
                v = int'(ram[a]);
                if (md == 1) acc += v;
                else if (wr == 0 && wc == 0 && wd == 0) acc = v;
                else if (v > acc) acc = v;
            end
            if (md == 1) begin
                q = acc / cnt;
                if ((acc % cnt) != 0 && acc < 0) q = q - 1;
                acc = q;
            end
            exp_data.push_back(acc);
        end
    endtask

    task automatic run_pass(input int s, input int md, input int low,
                            input bit has_first, input int first,
                            input int exp_n);
        int k, nout, ndone, first_rd, first_v, ai, pidx, first_d;
        bit pv, fin;
        logic signed [15:0] pd;
        k = 0; nout = 0; ndone = 0; first_rd = -1; first_v = -1;
        ai = 0; pv = 0; fin = 0; pidx = 0; pd = '0; first_d = 0;
        sel = s;
        build_model(s, md);
        @(negedge clk);
        chk("idle_busy", int'(m_busy), 0);
        mode = md[0];
        out_ready = 1'b1;
        start = 1'b1;
        while (k < 6000 && !fin) begin
            @(negedge clk);
            k++;
            out_ready = ($urandom_range(99) >= low);
            if (m_rd_en) begin
                if (first_rd < 0) first_rd = k;
                if (ai < exp_addr.size()) begin
                    if (int'(m_rd_addr) != exp_addr[ai])
                        chk("rd_addr", int'(m_rd_addr), exp_addr[ai]);
                end else begin
                    chk("extra_read", ai, exp_addr.size() - 1);
                end
                ai++;
            end
            if (pv) begin
                chk("stall_valid", int'(m_ov), 1);
                chk("stall_data", int'(m_od), int'(pd));
                chk("stall_idx", int'(m_oi), pidx);
            end
            pv = 0;
            if (m_ov) begin
                if (first_v < 0) first_v = k;
                if (m_rd_en) chk("emit_no_read", int'(m_rd_en), 0);
                if (out_ready) begin
                    if (nout == 0) first_d = int'(m_od);
                    chk("out_idx", int'(m_oi), nout);
                    if (nout < exp_data.size())
                        chk("out_data", int'(m_od), exp_data[nout]);
                    nout++;
                end else begin
                    pv = 1; pd = m_od; pidx = int'(m_oi);
                end
            end
            if (m_done) begin
                ndone++;
                fin = 1;
            end
            mode = 1'($urandom);
            start = m_ov ? 1'($urandom) : 1'b0;
        end
        start = 1'b0;
        if (!fin) chk("pass_timeout", k, 0);
        repeat (3) begin
            @(negedge clk);
            if (m_done) ndone++;
        end
        chk("done_pulses", ndone, 1);
        chk("out_count", nout, exp_n);
        chk("read_count", ai, exp_addr.size());
        if (has_first) chk("first_value", first_d, first);
        if (low == 0) begin
            chk("first_rd_cycle", first_rd, 1);
            chk("first_valid_cycle", first_v, pp[s] ** 3 + 2);
        end
    endtask

    typedef struct {
        int sel;
        int md;
        int fill;
        int low;
        bit has_first;
        int first;
        int n;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int k;
        tbl[0] = '{0, 0, 0, 0, 1, 21, 24};
        tbl[1] = '{0, 1, 1, 0, 1, -3, 24};
        tbl[2] = '{0, 1, 3, 0, 1, -1, 24};
        tbl[3] = '{0, 0, 2, 0, 1, -32761, 24};
        tbl[4] = '{1, 0, 0, 0, 1, 31, 16};
        tbl[5] = '{0, 0, 0, 30, 1, 21, 24};
        tbl[6] = '{0, 1, 4, 30, 0, 0, 24};
        tbl[7] = '{0, 0, 4, 30, 0, 0, 24};
        tbl[8] = '{2, 1, 4, 0, 0, 0, 27};
        tbl[9] = '{1, 1, 4, 30, 0, 0, 16};

        reset = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b0; sel = 0;
        fill(0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(m_busy), 0);
        chk("rst_done", int'(m_done), 0);
        chk("rst_rd_en", int'(m_rd_en), 0);
        chk("rst_rd_addr", int'(m_rd_addr), 0);
        chk("rst_valid", int'(m_ov), 0);
        chk("rst_data", int'(m_od), 0);
        chk("rst_idx", int'(m_oi), 0);

        for (int t = 0; t < 10; t++) begin
            fill(tbl[t].fill);
            run_pass(tbl[t].sel, tbl[t].md, tbl[t].low,
                     tbl[t].has_first, tbl[t].first, tbl[t].n);
        end

        // reset partway through the sixth window, then rerun from scratch
        fill(0);
        sel = 0; mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (k < 500 && !(m_rd_en && m_oi == 8'd5)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) chk("reach_window5", k, 0);
        repeat (3) @(negedge clk);
        chk("mid_busy", int'(m_busy), 1);
        reset = 1'b1;
        #1;
        chk("mrst_busy", int'(m_busy), 0);
        chk("mrst_rd_en", int'(m_rd_en), 0);
        chk("mrst_rd_addr", int'(m_rd_addr), 0);
        chk("mrst_valid", int'(m_ov), 0);
        chk("mrst_data", int'(m_od), 0);
        chk("mrst_idx", int'(m_oi), 0);
        chk("mrst_done", int'(m_done), 0);
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        repeat (5) begin
            @(negedge clk);
            if (m_done || m_busy) k++;
        end
        chk("no_done_after_rst", k, 0);
        run_pass(0, 0, 0, 1, 21, 24);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
